// File: rtl/tape_tx.sv
// rtl/tape_tx.sv - cassette output transmitter: CPU I/O port -> byte FIFO -> pulse-width encoded tape_out
module tape_tx #(
  parameter logic [7:0] DATA_PORT     = 8'h2F,
  parameter logic [7:0] CTRL_PORT     = 8'h2E,
  parameter int         FIFO_DEPTH    = 4,
  parameter int         HALF0         = 855,
  parameter int         HALF1         = 1710,
  parameter int         HALF_LEAD     = 2168,
  parameter int         HALF_SYNC     = 667,
  parameter int         LEADER_PULSES = 3223,
  parameter int         CW            = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] io_addr,
  input  logic [7:0] io_din,
  input  logic       iorq_n,
  input  logic       wr_n,
  input  logic       rd_n,
  output logic [7:0] dout,
  output logic       dout_en,
  output logic       tape_out,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LEAD_HI, LEAD_LO, SYNC_HI, SYNC_LO, BIT_HI, BIT_LO} state_t;

  state_t          state;
  logic [CW-1:0]   timer;
  logic [CW-1:0]   half_m1;
  logic [CW-1:0]   pulse_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            leader_armed;
  logic            overrun;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic            fifo_full, fifo_empty;

  logic data_wr, ctrl_wr, data_wr_q, ctrl_wr_q;
  logic push_req, ctrl_req, flush, pop, push_ok, half_done;

  assign data_wr = ~iorq_n & ~wr_n & (io_addr == DATA_PORT);
  assign ctrl_wr = ~iorq_n & ~wr_n & (io_addr == CTRL_PORT);

  // Only the first cycle of a held strobe acts.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_wr_q <= 1'b0;
      ctrl_wr_q <= 1'b0;
    end else begin
      data_wr_q <= data_wr;
      ctrl_wr_q <= ctrl_wr;
    end
  end

  assign push_req   = data_wr & ~data_wr_q;
  assign ctrl_req   = ctrl_wr & ~ctrl_wr_q;
  assign flush      = ctrl_req & io_din[1];
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  always_comb begin
    half_m1 = '0;
    case (state)
      LEAD_HI, LEAD_LO: half_m1 = CW'(HALF_LEAD - 1);
      SYNC_HI, SYNC_LO: half_m1 = CW'(HALF_SYNC - 1);
      BIT_HI, BIT_LO:   half_m1 = shreg[7] ? CW'(HALF1 - 1) : CW'(HALF0 - 1);
      default:          half_m1 = '0;
    endcase
  end

  assign half_done = (state != IDLE) && (timer == half_m1);
  assign pop       = ~fifo_empty & ((state == IDLE) |
                     ((state == BIT_LO) & half_done & (bit_cnt == 3'd0)));
  // A pop in the same cycle frees the slot a push on a full FIFO needs.
  assign push_ok   = push_req & ~flush & (~fifo_full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= io_din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (ctrl_req && io_din[2]) begin
      overrun <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      tape_out     <= 1'b0;
      timer        <= '0;
      pulse_cnt    <= '0;
      bit_cnt      <= 3'd0;
      shreg        <= 8'h00;
      leader_armed <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      tape_out     <= 1'b0;
      timer        <= '0;
      leader_armed <= 1'b0;
    end else begin
      if (ctrl_req && io_din[0]) leader_armed <= 1'b1;
      timer <= (state == IDLE || half_done) ? '0 : timer + CW'(1);
      case (state)
        IDLE: if (!fifo_empty) begin
          shreg    <= mem[rd_ptr];
          bit_cnt  <= 3'd7;
          tape_out <= 1'b1;
          if (leader_armed) begin
            state        <= LEAD_HI;
            leader_armed <= 1'b0;
            pulse_cnt    <= CW'(LEADER_PULSES - 1);
          end else begin
            state <= BIT_HI;
          end
        end
        LEAD_HI: if (half_done) begin
          state    <= LEAD_LO;
          tape_out <= 1'b0;
        end
        LEAD_LO: if (half_done) begin
          tape_out <= 1'b1;
          if (pulse_cnt == '0) begin
            state <= SYNC_HI;
          end else begin
            pulse_cnt <= pulse_cnt - CW'(1);
            state     <= LEAD_HI;
          end
        end
        SYNC_HI: if (half_done) begin
          state    <= SYNC_LO;
          tape_out <= 1'b0;
        end
        SYNC_LO: if (half_done) begin
          state    <= BIT_HI;
          tape_out <= 1'b1;
        end
        BIT_HI: if (half_done) begin
          state    <= BIT_LO;
          tape_out <= 1'b0;
        end
        BIT_LO: if (half_done) begin
          if (bit_cnt != 3'd0) begin
            shreg    <= {shreg[6:0], 1'b0};
            bit_cnt  <= bit_cnt - 3'd1;
            state    <= BIT_HI;
            tape_out <= 1'b1;
          end else if (!fifo_empty) begin
            // Back-to-back bytes: no gap and no leader.
            shreg    <= mem[rd_ptr];
            bit_cnt  <= 3'd7;
            state    <= BIT_HI;
            tape_out <= 1'b1;
          end else begin
            state    <= IDLE;
            tape_out <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tape_out <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = (state != IDLE) | ~fifo_empty;
  assign dout_en = ~iorq_n & ~rd_n & (io_addr == CTRL_PORT);
  assign dout    = dout_en ? {4'b0000, overrun, leader_armed, busy, fifo_full} : 8'hFF;

endmodule
